// File: rtl/sdwr_pkg.sv
// Shared types and constants for the SDWR serial write port.
package sdwr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2
    } state_e;

    localparam logic [3:0] REG_DATA = 4'h0;
    localparam logic [3:0] REG_CTRL = 4'h1;

    // Bus window: ba13=0, ba12=1
    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;

    localparam int DIV_W = 8;

endpackage

// File: rtl/sdwr_baud_div.sv
// Half-bit divider: tick_half pulses every max(div,1) enabled clocks, phase toggles on each tick.
module sdwr_baud_div
    import sdwr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             enable,
    output logic             tick_half,
    output logic             phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d, div_eff;
    logic             phase_q, phase_d;

    always_comb begin
        div_eff   = (div == '0) ? DIV_W'(1) : div;
        tick_half = enable && (cnt_q == div_eff - DIV_W'(1));
        cnt_d     = cnt_q + DIV_W'(1);
        phase_d   = phase_q;
        // Disabled means parked at the start of a low phase
        if (!enable) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick_half) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/sdwr_serializer.sv
// Bus-mapped MSB-first serial writer: DATA register starts a frame, CTRL sets the half-bit divider.
module sdwr_serializer
    import sdwr_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DIV_RST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sser_n,
    input  logic              ba13,
    input  logic              ba12,
    input  logic [3:0]        ba7_4,
    input  logic              br_w,
    input  logic              bus_stb,
    input  logic [DATA_W-1:0] bd,
    output logic              sdwr,
    output logic              sclk_o,
    output logic              sbusy,
    output logic              ovr
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Assert asynchronously, release two clocks after rst_n rises
    logic [1:0] rsync_q;
    logic       srst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsync_q <= 2'b00;
        else        rsync_q <= {rsync_q[0], 1'b1};
    end
    assign srst_n = rsync_q[1];

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  fdiv_q, fdiv_d;
    logic              ovr_q, ovr_d;
    logic              wr_stb, data_wr, ctrl_wr;
    logic              tick_half, phase;

    assign wr_stb  = !sser_n && (ba13 == WIN_BA13) && (ba12 == WIN_BA12) && !br_w && bus_stb;
    assign data_wr = wr_stb && (ba7_4 == REG_DATA);
    assign ctrl_wr = wr_stb && (ba7_4 == REG_CTRL);

    // fdiv_q is the divider snapshot for the running frame, so CTRL writes wait for the next one
    sdwr_baud_div u_div (
        .clk       (clk),
        .rst_n     (srst_n),
        .div       (fdiv_q),
        .enable    (state_q != ST_IDLE),
        .tick_half (tick_half),
        .phase     (phase)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        div_d    = div_q;
        fdiv_d   = fdiv_q;
        ovr_d    = ovr_q;

        if (ctrl_wr) begin
            div_d = bd[DIV_W-1:0];
            ovr_d = 1'b0;
        end
        if (data_wr && state_q != ST_IDLE) ovr_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (data_wr) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = bd;
                    bitcnt_d = '0;
                    fdiv_d   = div_q;
                end
            end
            ST_SHIFT: begin
                // End of a high phase is the sclk falling edge
                if (tick_half && phase) begin
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick_half) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            div_q    <= DIV_W'(DIV_RST);
            fdiv_q   <= DIV_W'(DIV_RST);
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            fdiv_q   <= fdiv_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sbusy  = (state_q != ST_IDLE);
    assign sclk_o = (state_q == ST_SHIFT) && phase;
    assign sdwr   = (state_q == ST_SHIFT) ? shreg_q[DATA_W-1] : 1'b1;
    assign ovr    = ovr_q;

endmodule

// File: tb/tb_sdwr_serializer.sv
// Scoreboard bench: stimulus pushes expected frames from a timing model, a monitor decodes the serial line.
module tb_sdwr_serializer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sser_n = 1'b1, ba13 = 1'b0, ba12 = 1'b1, br_w = 1'b1, bus_stb = 1'b0;
    logic [3:0]    ba7_4 = 4'h0;
    logic [DW-1:0] bd = '0;
    logic          sdwr, sclk_o, sbusy, ovr;

    sdwr_serializer #(.DATA_W(DW), .DIV_RST(4)) dut (
        .clk(clk), .rst_n(rst_n), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
        .ba7_4(ba7_4), .br_w(br_w), .bus_stb(bus_stb), .bd(bd),
        .sdwr(sdwr), .sclk_o(sclk_o), .sbusy(sbusy), .ovr(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         len;
        int         half;
    } frame_t;

    frame_t exp_q[$];
    int     chk_cnt = 0, pass_cnt = 0;
    int     edge_cnt = 0;
    int     mdl_div, free_at;
    logic   mdl_ovr;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic fail_now(input string nm);
        chk_cnt++;
        $display("FAIL %s: event not expected / timed out", nm);
    endtask

    task automatic model_reset();
        mdl_div = 4;
        mdl_ovr = 1'b0;
        free_at = 0;
        exp_q.delete();
    endtask

    // Issue one strobe at a negedge; it is sampled at the next rising edge
    task automatic strobe(input logic sn, input logic b13, input logic b12,
                          input logic [3:0] idx, input logic rw, input logic [7:0] d);
        int e, eff, len;
        frame_t f;
        e = edge_cnt + 1;
        sser_n = sn; ba13 = b13; ba12 = b12; ba7_4 = idx; br_w = rw; bd = d; bus_stb = 1'b1;
        if (!sn && !b13 && b12 && !rw) begin
            if (idx == 4'h0) begin
                if (e >= free_at) begin
                    eff = (mdl_div == 0) ? 1 : mdl_div;
                    len = 2 * eff * DW + eff;
                    f.data = d; f.len = len; f.half = eff;
                    exp_q.push_back(f);
                    free_at = e + len + 1;
                end else begin
                    mdl_ovr = 1'b1;
                end
            end else if (idx == 4'h1) begin
                mdl_div = int'(d);
                mdl_ovr = 1'b0;
            end
        end
        @(negedge clk);
        bus_stb = 1'b0; sser_n = 1'b1; br_w = 1'b1;
        chk("ovr_after_strobe", int'(ovr), int'(mdl_ovr));
    endtask

    task automatic data_wr(input logic [7:0] d); strobe(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, d); endtask
    task automatic ctrl_wr(input logic [7:0] d); strobe(1'b0, 1'b0, 1'b1, 4'h1, 1'b0, d); endtask

    task automatic wait_idle();
        bool_loop: for (int i = 0; i < 3000; i++) begin
            if (edge_cnt >= free_at && !sbusy) return;
            @(negedge clk);
        end
        fail_now("wait_idle_timeout");
    endtask

    // Monitor: decode frames from the serial pins and compare against the queue
    logic [7:0] got_bits;
    int         nbits, blen, hi;
    logic       prev_busy = 1'b0, prev_sclk = 1'b0, prev_sdwr = 1'b1;
    frame_t     ef;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0; prev_sclk = 1'b0; prev_sdwr = 1'b1;
        end else begin
            if (sbusy) begin
                if (!prev_busy) begin got_bits = '0; nbits = 0; blen = 0; hi = 0; end
                blen++;
                if (sclk_o && !prev_sclk) begin got_bits = {got_bits[6:0], sdwr}; nbits++; end
                if (sclk_o) hi++;
                if (!sclk_o && prev_sclk) begin
                    if (exp_q.size() > 0) chk("hi_phase_len", hi, exp_q[0].half);
                    else fail_now("hi_phase_no_frame");
                    hi = 0;
                end
                if (prev_busy && sdwr !== prev_sdwr)
                    chk("sdwr_changes_on_fall", int'(prev_sclk && !sclk_o), 1);
            end else if (prev_busy) begin
                if (exp_q.size() == 0) fail_now("unexpected_frame");
                else begin
                    ef = exp_q.pop_front();
                    chk("frame_data", int'(got_bits), int'(ef.data));
                    chk("frame_busy_len", blen, ef.len);
                    chk("frame_nbits", nbits, DW);
                end
                chk("idle_sdwr", int'(sdwr), 1);
            end
            prev_busy = sbusy; prev_sclk = sclk_o; prev_sdwr = sdwr;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_sdwr", int'(sdwr), 1);
        chk("rst_sclk", int'(sclk_o), 0);
        chk("rst_sbusy", int'(sbusy), 0);
        chk("rst_ovr", int'(ovr), 0);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 0xA5 at reset divider
        data_wr(8'hA5);
        wait_idle();

        // div=0 acts as 1
        ctrl_wr(8'h00);
        data_wr(8'hFF);
        wait_idle();

        // Overrun during a frame, cleared by CTRL write mid-frame
        data_wr(8'h3C);
        repeat (10) @(negedge clk);
        data_wr(8'h11);
        chk("ovr_set", int'(ovr), 1);
        ctrl_wr(8'h04);
        chk("ovr_cleared", int'(ovr), 0);
        wait_idle();

        // Ignored strobes
        strobe(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 8'h55);
        strobe(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'h55);
        strobe(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h55);
        strobe(1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 8'h55);
        repeat (2) @(negedge clk);
        chk("ignored_sbusy", int'(sbusy), 0);
        chk("ignored_sdwr", int'(sdwr), 1);
        chk("ignored_sclk", int'(sclk_o), 0);

        // STOP-exit write dropped, first-IDLE write accepted
        ctrl_wr(8'h02);
        data_wr(8'h5A);
        for (int i = 0; i < 200 && edge_cnt + 1 < free_at - 1; i++) @(negedge clk);
        data_wr(8'h96);
        data_wr(8'hC3);
        chk("ovr_stop_exit", int'(ovr), 1);
        ctrl_wr(8'h03);
        wait_idle();

        // Reset in the middle of bit 3 of 0x81
        ctrl_wr(8'h04);
        data_wr(8'h81);
        repeat (26) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        data_wr(8'h81);
        wait_idle();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) data_wr(8'($urandom));
            else if (op <= 6) ctrl_wr(8'($urandom_range(0, 3)));
            else if (op == 7) begin
                int k;
                k = $urandom_range(0, 4);
                case (k)
                    0: strobe(1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 1)), 1'b1, 8'($urandom));
                    1: strobe(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 1)), 1'b0, 8'($urandom));
                    2: strobe(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 1)), 1'b0, 8'($urandom));
                    3: strobe(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 1)), 1'b0, 8'($urandom));
                    default: strobe(1'b0, 1'b0, 1'b1, 4'($urandom_range(2, 15)), 1'b0, 8'($urandom));
                endcase
            end else begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sdwr_serializer.md
SDWR_SERIALIZER -- requirements
Module: sdwr_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the serial frame length in bits.
REQ-002 The block SHALL have parameter DIV_RST, default 4, giving the reset value of the half-bit divider.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 sser_n  in  1  serial-port select; active low.
REQ-006 ba13, ba12  in  1 each  window decode; the window is ba13=0, ba12=1.
REQ-007 ba7_4  in  4  register index.
REQ-008 br_w  in  1  bus direction; 1=read, 0=write.
REQ-009 bus_stb  in  1  one-cycle bus strobe.
REQ-010 bd  in  DATA_W  write data.
REQ-011 sdwr  out  1  serial data; idles high.
REQ-012 sclk_o  out  1  serial clock; idles low; receiver samples sdwr on its rising edge.
REQ-013 sbusy  out  1  frame in progress.
REQ-014 ovr  out  1  sticky overrun flag.

Function
REQ-015 A write strobe SHALL be the condition sser_n=0, ba13=0, ba12=1, br_w=0 and bus_stb=1; every other condition, including all reads, SHALL be ignored.
REQ-016 A write strobe with ba7_4=4'h0 (DATA) SHALL start a frame if the FSM is IDLE; otherwise it SHALL be dropped and ovr set to 1.
REQ-017 A write strobe with ba7_4=4'h1 (CTRL) SHALL load div from bd[7:0] and clear ovr; div=0 SHALL behave as div=1; a CTRL write during a frame SHALL take effect at the next frame only.
REQ-018 Write strobes with any other ba7_4 value SHALL have no effect.
REQ-019 The FSM states SHALL be IDLE, SHIFT and STOP.
REQ-020 IDLE->SHIFT on an accepted DATA write at edge n; sbusy=1 and the MSB on sdwr from edge n.
REQ-021 In SHIFT, each bit SHALL occupy 2*div clocks: sclk_o=0 for div clocks, then 1 for div clocks; sdwr SHALL change only when sclk_o falls.
REQ-022 Bits SHALL be sent MSB first.
REQ-023 SHIFT->STOP after the DATA_W-th high phase; STOP SHALL hold sdwr=1 and sclk_o=0 for div clocks, then go to IDLE with sbusy=0.
REQ-024 sbusy SHALL stay high for exactly 2*div*DATA_W+div clocks per frame.
REQ-025 A DATA write in the same cycle that STOP exits SHALL be dropped and SHALL set ovr.
REQ-026 A DATA write in the first IDLE cycle SHALL be accepted, giving back-to-back frames with no gap beyond STOP.
REQ-027 A simultaneous ovr-setting event and CTRL write SHALL NOT occur, because both require distinct ba7_4 values.
REQ-028 The bit counter SHALL be $clog2(DATA_W)+1 bits wide, and the divider counter 8 bits wide.

Reset
REQ-029 While rst_n=0, the outputs SHALL be sdwr=1, sclk_o=0, sbusy=0 and ovr=0, with the FSM in IDLE and div=DIV_RST.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; no partial bits SHALL be resumed after release.
REQ-031 Deassertion of reset SHALL be synchronised to clk before it releases the FSM.

Structure
REQ-032 The package sdwr_pkg SHALL hold the FSM state enum, the register index constants REG_DATA=4'h0 and REG_CTRL=4'h1, and the window decode constants.
REQ-033 The half-bit divider SHALL be a sub-module named sdwr_baud_div, with inputs div and enable and outputs tick_half and phase.
REQ-034 The shift register, bit counter and FSM SHALL reside in the top level.

Verification
REQ-035 After reset (div=4), a DATA write of 0xA5 SHALL produce the rising-edge samples 1,0,1,0,0,1,0,1, with sbusy high for 68 clocks, then sdwr=1.
REQ-036 A CTRL write of 0x00 followed by a DATA write of 0xFF SHALL give each bit 2 clocks, sbusy high for 17 clocks, and sdwr constant at 1.
REQ-037 A DATA write of 0x3C followed by a DATA write of 0x11 after 10 clocks SHALL transmit 0x3C only, with ovr=1; a CTRL write of 0x04 SHALL then clear ovr to 0.
REQ-038 A write strobe with br_w=1, or with sser_n=1, or with ba12=0, or with ba7_4=4'h7, SHALL leave sbusy=0 and the outputs unchanged.
REQ-039 Asserting rst_n=0 at bit 3 of a 0x81 frame SHALL force sdwr=1, sclk_o=0 and sbusy=0 within the same cycle; a new 0x81 after release SHALL transmit in full.
REQ-040 A DATA write in the first IDLE cycle after a frame SHALL be accepted, while a DATA write on the STOP exit cycle SHALL set ovr.
